// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies symbols by synchronized high time and
// assembles MSB-first G,R,B pixels into write strobes for a pixel buffer.
module ws2812_rx #(
    parameter int LED_COUNT        = 8,
    parameter int REVERSE          = 0,
    parameter int CYCLES_THRESHOLD = 32,
    parameter int CYCLES_HIGH_MAX  = 100,
    parameter int CYCLES_RESET     = 2500
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       data_i,
    output logic [8:0] address_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       we_o,
    output logic       frame_o,
    output logic       overflow_o,
    output logic       error_o
);

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam logic [11:0] THRESHOLD = 12'(CYCLES_THRESHOLD);
    localparam logic [11:0] HIGH_MAX  = 12'(CYCLES_HIGH_MAX);
    localparam logic [11:0] RESET_CNT = 12'(CYCLES_RESET);
    localparam logic [9:0]  LED_LAST  = 10'(LED_COUNT);
    localparam logic [8:0]  TOP_ADDR  = 9'(LED_COUNT - 1);

    logic        line_p0, line_p1, line_p2;
    logic        rise, fall;
    logic [11:0] high_cnt, low_cnt;
    logic [1:0]  state;
    logic [23:0] sr;
    logic [4:0]  bit_cnt;
    logic [9:0]  pix_cnt;
    logic        bits_seen;

    logic        bit_val;
    logic [23:0] sr_next;
    logic [8:0]  addr_calc;

    // Input stage: two-flop synchronizer plus one flop for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_p0 <= 1'b0;
            line_p1 <= 1'b0;
            line_p2 <= 1'b0;
        end else begin
            line_p0 <= data_i;
            line_p1 <= line_p0;
            line_p2 <= line_p1;
        end
    end

    assign rise = line_p1 & ~line_p2;
    assign fall = ~line_p1 & line_p2;

    // High count loads 1 on the rising edge so it equals the synchronized high
    // width in cycles when the falling edge is seen.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            high_cnt <= 12'd0;
            low_cnt  <= 12'd0;
        end else if (rise) begin
            high_cnt <= 12'd1;
            low_cnt  <= 12'd0;
        end else if (line_p1) begin
            if (high_cnt != CNT_MAX) high_cnt <= high_cnt + 12'd1;
        end else begin
            if (low_cnt != CNT_MAX) low_cnt <= low_cnt + 12'd1;
        end
    end

    assign bit_val   = (high_cnt >= THRESHOLD);
    assign sr_next   = {sr[22:0], bit_val};
    assign addr_calc = (REVERSE != 0) ? pix_cnt[8:0] : (TOP_ADDR - pix_cnt[8:0]);

    // Decode stage: symbol classification, pixel assembly and framing
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= SYNC;
            sr         <= 24'd0;
            bit_cnt    <= 5'd0;
            pix_cnt    <= 10'd0;
            bits_seen  <= 1'b0;
            address_o  <= 9'd0;
            r_o        <= 8'd0;
            g_o        <= 8'd0;
            b_o        <= 8'd0;
            we_o       <= 1'b0;
            frame_o    <= 1'b0;
            overflow_o <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            we_o       <= 1'b0;
            frame_o    <= 1'b0;
            overflow_o <= 1'b0;
            error_o    <= 1'b0;
            case (state)
                SYNC: begin
                    // Leaving SYNC starts a fresh frame silently.
                    if (low_cnt >= RESET_CNT) begin
                        state     <= IDLE;
                        pix_cnt   <= 10'd0;
                        bit_cnt   <= 5'd0;
                        bits_seen <= 1'b0;
                    end
                end
                IDLE: begin
                    if (low_cnt == RESET_CNT && bits_seen) begin
                        frame_o   <= 1'b1;
                        error_o   <= (bit_cnt != 5'd0);
                        pix_cnt   <= 10'd0;
                        bit_cnt   <= 5'd0;
                        bits_seen <= 1'b0;
                    end
                    if (rise) state <= HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        sr        <= sr_next;
                        bits_seen <= 1'b1;
                        state     <= IDLE;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= 5'd0;
                            if (pix_cnt == LED_LAST) begin
                                overflow_o <= 1'b1;
                            end else begin
                                we_o      <= 1'b1;
                                address_o <= addr_calc;
                                g_o       <= sr_next[23:16];
                                r_o       <= sr_next[15:8];
                                b_o       <= sr_next[7:0];
                                pix_cnt   <= pix_cnt + 10'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (high_cnt > HIGH_MAX) begin
                        error_o <= 1'b1;
                        bit_cnt <= 5'd0;
                        state   <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
